oversample_filter: RTL and testbench

//  Producer side of the pid_core input stream (data_in/data_valid_in).
//  - Block-averages 2^os signed ADC samples into one mean sample.
//  - Emits the mean with a one-cycle valid pulse.
//  - Sits between the ADC controller and pid_core; the ratio is set from frontpanel.

---
 rtl/oversample_filter_pkg.sv | 23 ++
 rtl/oversample_filter_accum.sv | 52 +++++
 rtl/oversample_filter.sv | 81 ++++++++
 tb/tb_oversample_filter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/oversample_filter_pkg.sv
// Shared definitions for the oversampling block-average filter.
// Holds the FSM state encoding and the width helpers used by the datapath.
package oversample_filter_pkg;

    localparam int unsigned W_ADC = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    // Accumulator needs one extra bit per doubling of the largest block.
    function automatic int unsigned acc_width(input int unsigned w_in, input int unsigned w_os);
        return w_in + (32'd1 << w_os) - 32'd1;
    endfunction

    // Sample counter wide enough to hold ratio-1 for the largest block.
    function automatic int unsigned cnt_width(input int unsigned w_os);
        return (32'd1 << w_os) - 32'd1;
    endfunction

endpackage

// File: rtl/oversample_filter_accum.sv
// Block accumulator: running signed sum and sample count for one block.
// Exposes the sum including the current sample and a last-sample flag.
module os_accum
    import oversample_filter_pkg::*;
#(
    parameter int unsigned W_IN  = W_ADC,
    parameter int unsigned W_OS  = 3,
    localparam int unsigned W_ACC = acc_width(W_IN, W_OS),
    localparam int unsigned W_CNT = cnt_width(W_OS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    add,
    input  logic signed [W_IN-1:0]  data,
    input  logic [W_OS-1:0]         os,
    output logic signed [W_ACC-1:0] total_c,
    output logic                    done_c
);

    logic signed [W_ACC-1:0] sum;
    logic [W_CNT-1:0]        count;
    logic [W_CNT:0]          count_inc;
    logic [W_CNT:0]          ratio;

    // One extra bit so a full 2^(2^W_OS-1) block compares without wrap.
    always_comb begin
        count_inc = {1'b0, count} + (W_CNT + 1)'(1);
        ratio     = (W_CNT + 1)'(1) << os;
        done_c    = (count_inc == ratio);
        total_c   = sum + W_ACC'(data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            count <= '0;
        end else if (clear) begin
            sum   <= '0;
            count <= '0;
        end else if (add) begin
            if (done_c) begin
                sum   <= '0;
                count <= '0;
            end else begin
                sum   <= total_c;
                count <= count + W_CNT'(1);
            end
        end
    end

endmodule

// File: rtl/oversample_filter.sv
// Block-averages 2^os signed ADC samples and emits the mean with a one-cycle strobe.
// Feeds the pid_core input stream; no backpressure, samples are never dropped.
module oversample_filter
    import oversample_filter_pkg::*;
#(
    parameter int unsigned W_IN  = W_ADC,
    parameter int unsigned W_OUT = 18,
    parameter int unsigned W_OS  = 3
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic signed [W_IN-1:0]  data_in,
    input  logic                    data_valid_in,
    input  logic [W_OS-1:0]         os_in,
    input  logic                    clear_in,
    input  logic                    update_en_in,
    input  logic                    update_in,
    output logic signed [W_OUT-1:0] data_out,
    output logic                    data_valid_out
);

    localparam int unsigned W_ACC = acc_width(W_IN, W_OS);

    state_t                  state;
    logic [W_OS-1:0]         os_active;
    logic                    flush_c;
    logic                    take_c;
    logic                    done_c;
    logic signed [W_ACC-1:0] total_c;
    logic signed [W_IN-1:0]  mean_c;

    // A clear or an accepted ratio update drops the partial block and any coincident sample.
    always_comb begin
        flush_c = clear_in | (update_in & update_en_in);
        take_c  = data_valid_in & ~flush_c;
        mean_c  = W_IN'(total_c >>> os_active);
    end

    os_accum #(
        .W_IN (W_IN),
        .W_OS (W_OS)
    ) u_accum (
        .clk     (clk_in),
        .rst     (reset_in),
        .clear   (flush_c),
        .add     (take_c),
        .data    (data_in),
        .os      (os_active),
        .total_c (total_c),
        .done_c  (done_c)
    );

    // ST_SEND also accepts a sample, which starts the next block without a gap.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state          <= ST_IDLE;
            os_active      <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            if (update_in && update_en_in) begin
                os_active <= os_in;
            end
            if (flush_c) begin
                state <= ST_IDLE;
            end else if (take_c) begin
                if (done_c) begin
                    state          <= ST_SEND;
                    data_valid_out <= 1'b1;
                    data_out       <= W_OUT'(mean_c);
                end else begin
                    state <= ST_ACCUM;
                end
            end else if (state == ST_SEND) begin
                state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_oversample_filter.sv
// Self-checking bench for oversample_filter: directed cases plus randomized traffic
// compared each cycle against a block-mean reference model.
module tb_oversample_filter;

    localparam int unsigned W_IN  = 18;
    localparam int unsigned W_OUT = 18;
    localparam int unsigned W_OS  = 3;

    logic                    clk_in = 1'b0;
    logic                    reset_in;
    logic signed [W_IN-1:0]  data_in;
    logic                    data_valid_in;
    logic [W_OS-1:0]         os_in;
    logic                    clear_in;
    logic                    update_en_in;
    logic                    update_in;
    logic signed [W_OUT-1:0] data_out;
    logic                    data_valid_out;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    longint      block_q[$];
    int unsigned os_m = 0;
    longint      exp_out = 0;
    longint      exp_valid = 0;

    always #5 clk_in = ~clk_in;

    oversample_filter #(
        .W_IN  (W_IN),
        .W_OUT (W_OUT),
        .W_OS  (W_OS)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .data_in        (data_in),
        .data_valid_in  (data_valid_in),
        .os_in          (os_in),
        .clear_in       (clear_in),
        .update_en_in   (update_en_in),
        .update_in      (update_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Mean of a block, rounded toward minus infinity.
    function automatic longint floor_mean(input longint s, input int unsigned os);
        longint r;
        longint q;
        r = longint'(1) << os;
        q = s / r;
        if ((s % r) != 0 && s < 0) q--;
        return q;
    endfunction

    // One clock: drive at negedge, update model and compare just after posedge.
    task automatic step(input logic v, input longint d, input logic clr,
                        input logic upd, input logic en, input logic [W_OS-1:0] os);
        longint s;
        @(negedge clk_in);
        data_valid_in = v;
        data_in       = W_IN'(d);
        clear_in      = clr;
        update_in     = upd;
        update_en_in  = en;
        os_in         = os;
        @(posedge clk_in);
        #1;
        exp_valid = 0;
        if (clr || (upd && en)) begin
            block_q.delete();
            if (upd && en) os_m = os;
        end else if (v) begin
            block_q.push_back(d);
            if (block_q.size() == (1 << os_m)) begin
                s = 0;
                foreach (block_q[i]) s += block_q[i];
                exp_out   = floor_mean(s, os_m);
                exp_valid = 1;
                block_q.delete();
            end
        end
        if (data_valid_out) pulses++;
        check("valid", longint'(data_valid_out), exp_valid);
        check("data", longint'(data_out), exp_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic set_os(input logic [W_OS-1:0] os);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1, os);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic mid_reset();
        #1;
        data_valid_in = 1'b0;
        reset_in      = 1'b1;
        #1;
        check("rst_data", longint'(data_out), 0);
        check("rst_valid", longint'(data_valid_out), 0);
        block_q.delete();
        os_m    = 0;
        exp_out = 0;
        #1;
        reset_in = 1'b0;
    endtask

    initial begin
        logic signed [W_IN-1:0] rd;
        int r;
        reset_in      = 1'b1;
        data_in       = '0;
        data_valid_in = 1'b0;
        os_in         = '0;
        clear_in      = 1'b0;
        update_en_in  = 1'b0;
        update_in     = 1'b0;
        #12;
        check("reset_data", longint'(data_out), 0);
        check("reset_valid", longint'(data_valid_out), 0);
        reset_in = 1'b0;

        // Ratio 1: every sample is its own block.
        set_os(0);
        step(1'b1, 100, 1'b0, 1'b0, 1'b0, '0);
        check("t1_first", longint'(data_out), 100);
        step(1'b1, -5, 1'b0, 1'b0, 1'b0, '0);
        check("t1_second", longint'(data_out), -5);
        idle(2);

        set_os(2);
        step(1'b1, 1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 2, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 3, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 6, 1'b0, 1'b0, 1'b0, '0);
        check("t2_mean", longint'(data_out), 3);
        idle(2);

        // Negative rounding toward -inf, then full-scale positive.
        for (int i = 0; i < 3; i++) step(1'b1, -1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, -2, 1'b0, 1'b0, 1'b0, '0);
        check("t3_neg", longint'(data_out), -2);
        for (int i = 0; i < 4; i++) step(1'b1, 131071, 1'b0, 1'b0, 1'b0, '0);
        check("t3_max", longint'(data_out), 131071);
        idle(1);

        set_os(3);
        pulses = 0;
        for (int i = 0; i < 16; i++) step(1'b1, i * 1000 - 7000, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        check("t4_pulses", longint'(pulses), 2);

        set_os(2);
        step(1'b1, 10, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 10, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 99, 1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 20, 1'b0, 1'b1, 1'b0, 3'd5);
        for (int i = 0; i < 4; i++) step(1'b1, 20, 1'b0, 1'b0, 1'b0, '0);
        check("t5_mean", longint'(data_out), 20);
        idle(1);

        step(1'b1, 500, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 700, 1'b0, 1'b0, 1'b0, '0);
        mid_reset();
        set_os(2);
        step(1'b1, -9, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 4, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 4, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 4, 1'b0, 1'b0, 1'b0, '0);
        check("t6_mean", longint'(data_out), 0);
        idle(1);

        // Randomized traffic with occasional clears, updates and resets.
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 999);
            rd = W_IN'($urandom);
            if (r < 3) begin
                mid_reset();
            end else if (r < 20) begin
                step($urandom_range(0, 1) == 1, longint'(rd), 1'b1, 1'b0, 1'b0, '0);
            end else if (r < 45) begin
                step($urandom_range(0, 1) == 1, longint'(rd), 1'b0, 1'b1,
                     $urandom_range(0, 3) != 0, W_OS'($urandom_range(0, 5)));
            end else begin
                step($urandom_range(0, 9) < 7, longint'(rd), 1'b0, 1'b0, 1'b0, '0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
